// File: rtl/pdl_stack_buffer.sv
// rtl/pdl_stack_buffer.sv - PDL stack buffer: pointer/index addressed RAM with push/pop/exchange
// Registered read path with valid strobe, sticky wrap flags.
module pdl_stack_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] l,
  input  logic              push,
  input  logic              pop,
  input  logic              rd,
  input  logic              wr,
  input  logic              asel,
  input  logic              ptr_ld,
  input  logic              idx_ld,
  input  logic [ADDR_W-1:0] ld_val,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] pdl,
  output logic              pdl_vld,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] idx,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TOP = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rw_addr;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] wa;
  logic              re;
  logic              we;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              ovf_evt;
  logic              unf_evt;

  assign rw_addr = asel ? idx : ptr;

  // ptr_ld suppresses push/pop but leaves random access running on the old ptr
  always_comb begin
    ra      = rw_addr;
    wa      = rw_addr;
    re      = 1'b0;
    we      = 1'b0;
    ptr_nxt = ptr;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (ptr_ld) begin
      ptr_nxt = ld_val;
      re      = rd;
      we      = wr;
    end else if (push && pop) begin
      re = 1'b1;
      we = 1'b1;
      ra = ptr;
      wa = ptr;
    end else if (push) begin
      we      = 1'b1;
      wa      = ptr + 1'b1;
      ptr_nxt = ptr + 1'b1;
      ovf_evt = (ptr == TOP);
    end else if (pop) begin
      re      = 1'b1;
      ra      = ptr;
      ptr_nxt = ptr - 1'b1;
      unf_evt = (ptr == '0);
    end else begin
      re = rd;
      we = wr;
    end
  end

  // Write gated by reset so nothing lands once reset is asserted
  always_ff @(posedge clk) begin
    if (we && reset) mem[wa] <= l;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pdl     <= '0;
      pdl_vld <= 1'b0;
    end else begin
      pdl_vld <= re;
      if (re) pdl <= mem[ra];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      idx       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      if (idx_ld) idx <= ld_val;
      overflow  <= ovf_evt | (overflow & ~clr_flags);
      underflow <= unf_evt | (underflow & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_pdl_stack_buffer.sv
// tb/tb_pdl_stack_buffer.sv - bench for pdl_stack_buffer against a stack/array reference model
module tb_pdl_stack_buffer;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] l;
  logic          push, pop, rd, wr, asel, ptr_ld, idx_ld, clr_flags;
  logic [AW-1:0] ld_val;
  logic [DW-1:0] pdl;
  logic          pdl_vld;
  logic [AW-1:0] ptr, idx;
  logic          overflow, underflow;

  pdl_stack_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .l(l), .push(push), .pop(pop), .rd(rd), .wr(wr),
    .asel(asel), .ptr_ld(ptr_ld), .idx_ld(idx_ld), .ld_val(ld_val),
    .clr_flags(clr_flags), .pdl(pdl), .pdl_vld(pdl_vld), .ptr(ptr), .idx(idx),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mm [DEPTH];
  int            mptr, midx;
  logic          mov, mun, mvld;
  logic [DW-1:0] mpdl;
  int            ncmp = 0;
  int            nfail = 0;

  task automatic check(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ptr"}, DW'(ptr), DW'(mptr));
    check({tag, ".idx"}, DW'(idx), DW'(midx));
    check({tag, ".vld"}, DW'(pdl_vld), DW'(mvld));
    check({tag, ".pdl"}, pdl, mpdl);
    check({tag, ".ovf"}, DW'(overflow), DW'(mov));
    check({tag, ".unf"}, DW'(underflow), DW'(mun));
  endtask

  task automatic idle_inputs();
    push = 0; pop = 0; rd = 0; wr = 0; asel = 0; ptr_ld = 0; idx_ld = 0;
    clr_flags = 0; ld_val = '0; l = '0;
  endtask

  task automatic model_reset();
    mptr = 0; midx = 0; mov = 0; mun = 0; mvld = 0; mpdl = '0;
  endtask

  // Stack semantics: ptr is the top-of-stack word; reads always see pre-write contents
  task automatic model_cycle(input logic i_push, i_pop, i_rd, i_wr, i_asel, i_pld,
                             i_ild, input int i_ldv, input logic i_clr, input logic [DW-1:0] i_l);
    int a;
    a = i_asel ? midx : mptr;
    mvld = 0;
    if (i_clr) begin mov = 0; mun = 0; end
    if (i_pld || !(i_push || i_pop)) begin
      if (i_rd) begin mpdl = mm[a]; mvld = 1; end
      if (i_wr) mm[a] = i_l;
      if (i_pld) mptr = i_ldv;
    end else if (i_push && i_pop) begin
      mpdl = mm[mptr]; mvld = 1;
      mm[mptr] = i_l;
    end else if (i_push) begin
      if (mptr == DEPTH - 1) mov = 1;
      mptr = (mptr + 1) % DEPTH;
      mm[mptr] = i_l;
    end else begin
      mpdl = mm[mptr]; mvld = 1;
      if (mptr == 0) mun = 1;
      mptr = (mptr + DEPTH - 1) % DEPTH;
    end
    if (i_ild) midx = i_ldv;
  endtask

  task automatic step(input string tag, input logic i_push, i_pop, i_rd, i_wr, i_asel,
                      i_pld, i_ild, input int i_ldv, input logic i_clr,
                      input logic [DW-1:0] i_l);
    push = i_push; pop = i_pop; rd = i_rd; wr = i_wr; asel = i_asel;
    ptr_ld = i_pld; idx_ld = i_ild; ld_val = AW'(i_ldv); clr_flags = i_clr; l = i_l;
    @(posedge clk);
    model_cycle(i_push, i_pop, i_rd, i_wr, i_asel, i_pld, i_ild, i_ldv, i_clr, i_l);
    #1;
    idle_inputs();
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] keep;
    int            r;
    idle_inputs();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1;

    // fill the whole RAM so every later read has a known expectation
    step("fill_ld", 0, 0, 0, 0, 0, 1, 0, 1023, 0, '0);
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 0, 0, 0, 0, 0, 0, $urandom);
    step("fill_clr", 0, 0, 0, 0, 0, 0, 0, 0, 1, '0);

    step("ld0", 0, 0, 0, 0, 0, 1, 0, 0, 0, '0);
    step("push1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111);
    check("push1.ptr_k", DW'(ptr), 32'd1);
    step("push2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22222222);
    step("push3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h33333333);
    check("push3.ptr_k", DW'(ptr), 32'd3);
    step("pop1", 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    check("pop1.pdl_k", pdl, 32'h33333333);
    step("pop2", 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    check("pop2.pdl_k", pdl, 32'h22222222);
    step("pop3", 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    check("pop3.pdl_k", pdl, 32'h11111111);
    check("pop3.ptr_k", DW'(ptr), 32'd0);
    step("idle_vld", 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    check("idle.vld_k", DW'(pdl_vld), 32'd0);

    step("wrap_ld", 0, 0, 0, 0, 0, 1, 0, 1023, 0, '0);
    step("wrap_push", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    check("wrap_push.ovf_k", DW'(overflow), 32'd1);
    step("wrap_pop", 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    check("wrap_pop.pdl_k", pdl, 32'hDEADBEEF);
    check("wrap_pop.ptr_k", DW'(ptr), 32'd1023);
    check("wrap_pop.unf_k", DW'(underflow), 32'd1);
    step("clr", 0, 0, 0, 0, 0, 0, 0, 0, 1, '0);

    step("xchg_ld", 0, 0, 0, 0, 0, 1, 0, 5, 0, '0);
    step("xchg_wr", 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hAAAA0000);
    step("xchg", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000BBBB);
    check("xchg.pdl_k", pdl, 32'hAAAA0000);
    step("xchg_rd", 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
    check("xchg_rd.pdl_k", pdl, 32'h0000BBBB);

    step("idx_ld", 0, 0, 0, 0, 0, 0, 1, 100, 0, '0);
    step("idx_wr", 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h12345678);
    step("idx_rd", 0, 0, 1, 0, 1, 0, 0, 0, 0, '0);
    check("idx_rd.pdl_k", pdl, 32'h12345678);
    step("idx_rdwr", 0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h9);
    check("idx_rdwr.pdl_k", pdl, 32'h12345678);
    step("idx_rd2", 0, 0, 1, 0, 1, 0, 0, 0, 0, '0);
    check("idx_rd2.pdl_k", pdl, 32'h9);

    step("ign_ld", 0, 0, 0, 0, 0, 0, 1, 7, 0, '0);
    keep = mm[7];
    step("ign_push", 1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h77777777);
    step("ign_rd", 0, 0, 1, 0, 1, 0, 0, 0, 0, '0);
    check("ign_rd.pdl_k", pdl, keep);
    step("ldpush", 1, 0, 0, 0, 0, 1, 0, 20, 0, 32'h55555555);
    check("ldpush.ptr_k", DW'(ptr), 32'd20);
    step("ldpush_rd", 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);

    // reset asserted while a push is pending: no write may complete
    step("rst_ld", 0, 0, 0, 0, 0, 1, 1, 4, 0, '0);
    keep = mm[5];
    push = 1; l = 32'hCAFEF00D;
    #2;
    reset = 0;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1;
    check_all("rst_hold");
    step("rst_ild", 0, 0, 0, 0, 0, 0, 1, 5, 0, '0);
    step("rst_rd", 0, 0, 1, 0, 1, 0, 0, 0, 0, '0);
    check("rst_rd.pdl_k", pdl, keep);

    for (int n = 0; n < 600; n++) begin
      logic b_push, b_pop, b_pld;
      int   v;
      r      = $urandom_range(0, 99);
      b_push = (r < 30) || (r >= 90);
      b_pop  = (r >= 30 && r < 55) || (r >= 90);
      b_pld  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       v = 0;
        1:       v = DEPTH - 1;
        default: v = $urandom_range(0, DEPTH - 1);
      endcase
      step("rand", b_push, b_pop, 1'($urandom), 1'($urandom), 1'($urandom), b_pld,
           ($urandom_range(0, 7) == 0), v, ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
